// File: rtl/mul_seq_responder.sv
// Iterative radix-2 shift-add multiplier behind an ap_ctrl_hs callee handshake.
// Operands are latched on accept. The engine runs WIDTH add/shift iterations,
// except that a zero operand skips straight to completion. The product is then
// presented on ap_return with a one-cycle ap_done pulse.
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst_n   asynchronous active-low reset
//   ap_start   level request from the initiator, sampled only in IDLE
//   ap_done    one-cycle completion pulse; ap_return valid in that cycle
//   ap_idle    high in IDLE while ap_start is low
//   ap_ready   high in the accept cycle (IDLE and ap_start)
//   a, b       unsigned operands, WIDTH bits each
//   ap_return  unsigned product, 2*WIDTH bits; held until the next completion
module mul_seq_responder #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_idle,
    output logic                 ap_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   ap_return
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        CALC = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PW-1:0]      acc_q;
    logic [PW-1:0]      mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept_c;
    logic               zero_op_c;
    logic               last_iter_c;
    logic [PW-1:0]      acc_step_c;

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d     = state_q;
        ap_ready    = 1'b0;
        ap_idle     = 1'b0;
        ap_done     = 1'b0;
        accept_c    = 1'b0;
        zero_op_c   = (a == '0) || (b == '0);
        last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));
        acc_step_c  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        unique case (state_q)
            IDLE: begin
                ap_idle  = !ap_start;
                ap_ready = ap_start;
                accept_c = ap_start;
                if (ap_start) begin
                    state_d = zero_op_c ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ap_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift-add datapath and the registered result copy
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            ap_return <= '0;
        end else begin
            if (accept_c) begin
                mcand_q  <= {{WIDTH{1'b0}}, a};
                mplier_q <= b;
                acc_q    <= '0;
                cnt_q    <= '0;
                // Zero-operand shortcut completes with a zero product.
                if (zero_op_c) begin
                    ap_return <= '0;
                end
            end else if (state_q == CALC) begin
                acc_q    <= acc_step_c;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNT_W'(1);
                // Capture the final sum on the edge into DONE.
                if (last_iter_c) begin
                    ap_return <= acc_step_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_responder.sv
// Directed test bench for mul_seq_responder with WIDTH=64.
module tb_mul_seq_responder;

    logic          ap_clk;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_done;
    logic          ap_idle;
    logic          ap_ready;
    logic [63:0]   a;
    logic [63:0]   b;
    logic [127:0]  ap_return;

    int total = 0;
    int bad   = 0;

    mul_seq_responder #(.WIDTH(64)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .ap_ready  (ap_ready),
        .a         (a),
        .b         (b),
        .ap_return (ap_return)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait for ap_done, counting cycles after the accept edge (cycle 0 = accept cycle).
    // Also flags any ap_ready seen while the operation is in flight.
    task automatic wait_done(input string tag, input int exp_lat, input logic [127:0] expv);
        int cyc;
        bit seen;
        bit rdy_busy;
        cyc      = 0;
        seen     = 1'b0;
        rdy_busy = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge ap_clk);
            cyc++;
            if (ap_done) seen = 1'b1;
            if (ap_ready) rdy_busy = 1'b1;
            if (!ap_done && ap_idle) rdy_busy = 1'b1;
        end
        chk({tag, "_lat"}, 128'(cyc), 128'(exp_lat));
        chk({tag, "_ret"}, ap_return, expv);
        chk({tag, "_busy_hs"}, 128'(rdy_busy), 128'(0));
    endtask

    // Single operation: start held only until ap_ready, operands scrambled after accept.
    task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                          input logic [127:0] expv, input int exp_lat);
        @(posedge ap_clk); #1;
        a        = ta;
        b        = tb_v;
        ap_start = 1'b1;
        @(negedge ap_clk);
        chk({tag, "_rdy"}, 128'(ap_ready), 128'(1));
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        a        = ~ta;
        b        = ~tb_v;
        wait_done(tag, exp_lat, expv);
        @(negedge ap_clk);
        chk({tag, "_idle_after"}, 128'(ap_idle), 128'(1));
        chk({tag, "_done_drop"}, 128'(ap_done), 128'(0));
    endtask

    initial begin
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        a        = '0;
        b        = '0;

        // 1: reset state
        repeat (3) @(negedge ap_clk);
        chk("rst_in_idle", 128'(ap_idle), 128'(1));
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst_idle",  128'(ap_idle),  128'(1));
        chk("rst_done",  128'(ap_done),  128'(0));
        chk("rst_ready", 128'(ap_ready), 128'(0));
        chk("rst_ret",   ap_return,      128'(0));

        // 2: basic product, full iteration latency
        run_op("p3x5", 64'd3, 64'd5, 128'd15, 65);

        // 3: largest operands
        run_op("pmax", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 65);

        // 4: zero-operand shortcut on either side
        run_op("za", 64'd0, 64'h1234, 128'd0, 1);
        run_op("zb", 64'h1234, 64'd0, 128'd0, 1);
        run_op("p1xb", 64'd1, 64'h8000_0000_0000_0001, 128'h8000_0000_0000_0001, 65);

        // 5: back-to-back with ap_start held high
        begin
            int gap;
            @(posedge ap_clk); #1;
            a        = 64'd7;
            b        = 64'd6;
            ap_start = 1'b1;
            @(negedge ap_clk);
            chk("b2b_rdy1", 128'(ap_ready), 128'(1));
            @(posedge ap_clk); #1;
            a = 64'd2;
            b = 64'd9;
            wait_done("b2b_1", 65, 128'd42);
            chk("b2b_rdy_not_done", 128'(ap_ready), 128'(0));
            gap = 0;
            do begin
                @(negedge ap_clk);
                gap++;
            end while (!ap_ready && gap < 10);
            chk("b2b_period", 128'(65 + gap), 128'(66));
            chk("b2b_idle_held", 128'(ap_idle), 128'(0));
            @(posedge ap_clk); #1;
            ap_start = 1'b0;
            wait_done("b2b_2", 65, 128'd18);
        end

        // 6: reset asserted mid-calculation
        @(posedge ap_clk); #1;
        a        = 64'hABCD;
        b        = 64'h1111;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        repeat (29) @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_done", 128'(ap_done), 128'(0));
        chk("mid_rst_ret",  ap_return,     128'(0));
        chk("mid_rst_idle", 128'(ap_idle), 128'(1));
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        begin
            bit stray;
            stray = 1'b0;
            repeat (70) begin
                @(negedge ap_clk);
                if (ap_done) stray = 1'b1;
            end
            chk("mid_rst_no_pulse", 128'(stray), 128'(0));
        end
        run_op("p10x10", 64'd10, 64'd10, 128'd100, 65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
